// File: rtl/spi_master_sched.sv
// spi_master_sched: shared SPI master with a round-robin scheduler.
// Each requester supplies its byte and SPI mode. The winner gets the bus for
// one 8-bit MSB-first full-duplex transfer, and the received byte comes back
// with a one-cycle done pulse.
// Build option: define SPI_SCHED_LOOPBACK_EN to feed the internal mosi back
// into the receive shift register in place of the miso pin (self-test).
module spi_master_sched #(
  parameter int NREQ     = 4,
  parameter int CLK_DIV  = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] tx_data,
  input  logic [NREQ-1:0]   cpol,
  input  logic [NREQ-1:0]   cpha,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              sclk,
  output logic [NREQ-1:0]   ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned N  = NREQ;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last_served, win, win_r;
  logic            found;
  logic [NREQ-1:0] elig;
  logic [DW-1:0]   div_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [3:0]      edge_cnt;
  logic [7:0]      tx_sh, rx_sh;
  logic [7:0]      win_byte;
  logic            cpha_r;
  logic            div_tick, grant, edge_now, finish, sample, drive;
  logic            sin;

`ifdef SPI_SCHED_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sin = mosi;
`else
  assign sin = miso;
`endif

  // Round-robin pick: first eligible request above last_served, wrapping.
  // The requester being served this cycle (done high) is not eligible.
  always_comb begin
    elig  = req & ~done;
    found = 1'b0;
    win   = last_served;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned p;
      p = (32'(last_served) + k) % N;
      if (!found && elig[IW'(p)]) begin
        found = 1'b1;
        win   = IW'(p);
      end
    end
  end

  assign win_byte = tx_data[{win, 3'b000} +: 8];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_nx = state;
    div_tick = (div_cnt == DIV_LAST);
    grant    = 1'b0;
    edge_now = 1'b0;
    finish   = 1'b0;
    // edge_cnt holds edges already made, so this edge is number edge_cnt+1;
    // cpha=0 samples on odd edges, cpha=1 on even ones.
    sample   = (edge_cnt[0] == cpha_r);
    drive    = !sample && !(!cpha_r && edge_cnt == 4'd15);
    unique case (state)
      IDLE: if (found) begin
        grant    = 1'b1;
        state_nx = SETUP;
      end
      SETUP: if (div_tick) state_nx = XFER;
      XFER: if (div_tick) begin
        edge_now = 1'b1;
        if (edge_cnt == 4'd15) state_nx = HOLD;
      end
      HOLD: if (hold_cnt == HOLD_LAST) begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: timing counters, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk        <= 1'b0;
      ss_n        <= '1;
      mosi        <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      rx_data     <= '0;
      busy        <= 1'b0;
      last_served <= IW'(N - 1);
      win_r       <= '0;
      cpha_r      <= 1'b0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      div_cnt     <= '0;
      hold_cnt    <= '0;
      edge_cnt    <= '0;
    end else begin
      done <= '0;
      if (state == SETUP || state == XFER) div_cnt <= div_tick ? '0 : div_cnt + 1'b1;
      else                                 div_cnt <= '0;
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else               hold_cnt <= '0;

      if (grant) begin
        win_r    <= win;
        gnt      <= NREQ'(1) << win;
        ss_n     <= ~(NREQ'(1) << win);
        busy     <= 1'b1;
        cpha_r   <= cpha[win];
        sclk     <= cpol[win];
        edge_cnt <= '0;
        if (!cpha[win]) begin
          mosi  <= win_byte[7];
          tx_sh <= {win_byte[6:0], 1'b0};
        end else begin
          tx_sh <= win_byte;
        end
      end

      if (edge_now) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
        if (sample) rx_sh <= {rx_sh[6:0], sin};
        if (drive) begin
          mosi  <= tx_sh[7];
          tx_sh <= {tx_sh[6:0], 1'b0};
        end
      end

      if (finish) begin
        ss_n        <= '1;
        gnt         <= '0;
        done        <= gnt;
        rx_data     <= rx_sh;
        last_served <= win_r;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// Scoreboard bench for spi_master_sched: stimulus posts expected transfers
// into a queue; a monitor pops and checks on each done pulse, and an SPI
// slave model returns per-requester bytes and records what it saw on mosi.
module tb_spi_master_sched;

  localparam int N   = 4;
  localparam int CD  = 4;
  localparam int HC  = 2;
  localparam int LAT = 17 * CD + HC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] tx_data;
  logic [3:0]  cpol, cpha;
  logic [3:0]  gnt, done, ss_n;
  logic [7:0]  rx_data;
  logic        busy, sclk, mosi, miso;

  always #5 clk = ~clk;

  spi_master_sched #(.NREQ(N), .CLK_DIV(CD), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .tx_data(tx_data), .cpol(cpol),
    .cpha(cpha), .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  typedef struct {
    int         idx;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       pol;
    logic       pha;
    logic [7:0] sb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic chk_gap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: mode taken from the transfer at the head of the scoreboard.
  logic       miso_drv = 1'b0;
  logic [7:0] s_sh, s_rx;
  int         s_cnt, s_rise;
  logic       s_act = 1'b0, s_pha, s_prev;

`ifdef SPI_SCHED_LOOPBACK_EN
  assign miso = 1'b1;
`else
  assign miso = miso_drv;
`endif

  initial forever begin
    @(negedge clk);
    if (!rst_n || &ss_n) begin
      s_act = 1'b0;
    end else if (!s_act) begin
      s_act  = 1'b1;
      s_cnt  = 0;
      s_rise = 0;
      s_rx   = 8'h00;
      s_prev = sclk;
      s_pha  = (q.size() > 0) ? q[0].pha : 1'b0;
      s_sh   = (q.size() > 0) ? q[0].sb  : 8'h00;
      if (!s_pha) begin
        miso_drv = s_sh[7];
        s_sh     = {s_sh[6:0], 1'b0};
      end
    end else if (sclk !== s_prev) begin
      s_cnt++;
      if (sclk) s_rise++;
      s_prev = sclk;
      if (((s_cnt % 2) == 1) != s_pha) begin
        s_rx = {s_rx[6:0], mosi};
      end else if (!(!s_pha && s_cnt == 16)) begin
        miso_drv = s_sh[7];
        s_sh     = {s_sh[6:0], 1'b0};
      end
    end
  end

  // Monitor: checks each grant against the queue head, pops on done.
  initial begin
    logic [3:0] pg;
    int gnt_cyc, done_cyc;
    exp_t e;
    pg = '0; gnt_cyc = 0; done_cyc = -100;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (gnt != 0 && pg == 0) begin
          gnt_cyc = cyc;
          if (q.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
          else begin
            chk("gnt_winner", 32'(gnt), 32'(4'b0001 << q[0].idx));
            chk("ss_n_setup", 32'(ss_n), 32'(4'(~(4'b0001 << q[0].idx))));
            chk("sclk_setup", 32'(sclk), 32'(q[0].pol));
            if (!q[0].pha) chk("mosi_setup", 32'(mosi), 32'(q[0].tx[7]));
            chk("busy_setup", 32'(busy), 1);
            if (chk_gap) chk("idle_gap", 32'(cyc - done_cyc), 1);
          end
        end
        if (done != 0) begin
          if (q.size() == 0) chk("done_unexpected", 32'(done), 0);
          else begin
            e = q.pop_front();
            chk("done_onehot", 32'(done), 32'(4'b0001 << e.idx));
            chk("rx_data", 32'(rx_data), 32'(e.rx));
            chk("slave_mosi_byte", 32'(s_rx), 32'(e.tx));
            chk("latency", 32'(cyc - gnt_cyc), LAT);
            chk("rising_edges", 32'(s_rise), 8);
            chk("sclk_idle", 32'(sclk), 32'(e.pol));
            chk("ss_n_done", 32'(ss_n), 32'hf);
            chk("gnt_done", 32'(gnt), 0);
            done_cyc = cyc;
          end
        end
      end
      pg = gnt;
    end
  end

  task automatic post(input int i, input logic [7:0] tx, input logic pol,
                      input logic pha, input logic [7:0] sb);
    exp_t e;
    tx_data[8*i +: 8] = tx;
    cpol[i] = pol;
    cpha[i] = pha;
    e.idx = i; e.tx = tx; e.pol = pol; e.pha = pha; e.sb = sb;
`ifdef SPI_SCHED_LOOPBACK_EN
    e.rx = tx;
`else
    e.rx = sb;
`endif
    q.push_back(e);
  endtask

  task automatic wait_gnt(input int i);
    int t = 0;
    while (gnt[i] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("gnt_wait", 32'(gnt[i]), 1);
  endtask

  // Waits for n done pulses, dropping each served req unless kept; checks the
  // back-to-back gap after the first one when gap is set.
  task automatic serve(input int n, input logic [3:0] keep, input logic gap);
    int got = 0;
    int t = 0;
    while (got < n && t < 200 * n) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          got++;
          if (!keep[i]) req[i] = 1'b0;
        end
      end
      if (got >= 1 && gap) chk_gap = 1'b1;
      if (got >= n) req = '0;
    end
    chk_gap = 1'b0;
    chk("serve_count", 32'(got), 32'(n));
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'($urandom);
    tx_data = $urandom;
    cpol    = 4'($urandom);
    cpha    = 4'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_ss_n", 32'(ss_n), 32'hf);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx", 32'(rx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    req = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0; inputs changed after grant must not matter.
    post(0, 8'h73, 1'b0, 1'b0, 8'hA5);
    req[0] = 1'b1;
    wait_gnt(0);
    tx_data[7:0] = 8'hFF; cpol[0] = 1'b1; cpha[0] = 1'b1;
    serve(1, 4'b0000, 1'b0);

    // Mode 3, then idle levels hold.
    post(1, 8'hC3, 1'b1, 1'b1, 8'h5A);
    req[1] = 1'b1;
    serve(1, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    chk("idle_sclk", 32'(sclk), 1);
    chk("idle_mosi", 32'(mosi), 1);
    chk("idle_busy", 32'(busy), 0);

    // Fresh pointer, then all four request together.
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    post(0, 8'h11, 1'b0, 1'b0, 8'h81);
    post(1, 8'h22, 1'b1, 1'b1, 8'h42);
    post(2, 8'h44, 1'b0, 1'b1, 8'h24);
    post(3, 8'h88, 1'b1, 1'b0, 8'h18);
    req = 4'b1111;
    serve(4, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);

    // Requesters 0 and 2 held high: strict alternation, one idle cycle.
    post(0, 8'hE7, 1'b0, 1'b1, 8'h3B);
    post(2, 8'h0F, 1'b1, 1'b0, 8'hF0);
    post(0, 8'hE7, 1'b0, 1'b1, 8'h3B);
    post(2, 8'h0F, 1'b1, 1'b0, 8'hF0);
    req = 4'b0101;
    serve(4, 4'b0101, 1'b1);
    repeat (3) @(negedge clk);

    // Dropping req mid-transfer is not an abort.
    post(3, 8'h96, 1'b0, 1'b0, 8'h69);
    req[3] = 1'b1;
    wait_gnt(3);
    repeat (30) @(negedge clk);
    req[3] = 1'b0;
    serve(1, 4'b0000, 1'b0);

    // Reset after edge 5; the queued entry is served by the fresh transfer.
    post(2, 8'h5C, 1'b1, 1'b0, 8'hC5);
    req[2] = 1'b1;
    wait_gnt(2);
    repeat (26) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", 32'(ss_n), 32'hf);
    chk("midrst_sclk", 32'(sclk), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    serve(1, 4'b0000, 1'b0);

`ifdef SPI_SCHED_LOOPBACK_EN
    post(1, 8'h3C, 1'b0, 1'b0, 8'h00);
    req[1] = 1'b1;
    serve(1, 4'b0000, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_sched.md
# spi_master_sched

Shared SPI master with a built-in round-robin scheduler for up to NREQ local requesters. Each requester posts one byte and its own SPI mode (CPOL/CPHA). The block grants the bus to one requester at a time and drives that requester's active-low slave select. It runs one 8-bit full-duplex transfer, MSB first, and returns the received byte. It sits between on-chip clients and the external SPI pins, and is the master-side counterpart of `spi_slave`.

## Interface
- NREQ, 4, number of requesters (2..8)
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
- HOLD_CYC, 2, clk cycles SS stays low after the last SCLK edge (>=1)

- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester transfer request; level, held until the matching done
- tx_data  in  8*NREQ  byte for requester i at [8i+7:8i]
- cpol  in  NREQ  per-requester SCLK idle level
- cpha  in  NREQ  per-requester phase; 0 = sample on the leading edge, 1 = sample on the trailing edge
- gnt  out  NREQ  one-hot; high for the winner from SETUP through HOLD
- done  out  NREQ  one-cycle pulse to the served requester
- rx_data  out  8  received byte; updates with done and holds until the next done
- busy  out  1  high in any state other than IDLE
- sclk  out  1  SPI clock
- ss_n  out  NREQ  per-slave select, active-low, at most one low
- mosi  out  1  serial data out
- miso  in  1  serial data in

## Operation
- **Reset values** (reset asserts immediately, from any state): sclk=0, ss_n=all 1, mosi=0, gnt=0, done=0, rx_data=0, busy=0. FSM goes to IDLE and the RR pointer resets so requester 0 has highest priority.
- **FSM states:** IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- **IDLE**
  - If any req bit is eligible, the RR winner is chosen: the first set bit searching upward from last_served+1, wrapping.
  - The winner is registered and the FSM moves to SETUP.
  - tx_data, cpol and cpha of the winner are captured at this point. Later changes to these inputs are ignored until the next grant.
- **SETUP** (CLK_DIV cycles)
  - sclk = captured cpol.
  - ss_n[winner]=0 and gnt[winner]=1.
  - If cpha=0, mosi = bit 7.
- **XFER**
  - 16 SCLK edges, one every CLK_DIV cycles; edges are numbered 1..16.
  - cpha=0: sample miso on odd edges into the LSB of the shift register; drive the next bit on even edges (not on edge 16).
  - cpha=1: drive the next bit on odd edges (edge 1 drives bit 7); sample on even edges.
  - After edge 16, sclk is back at cpol and the FSM moves to HOLD.
- **HOLD** (HOLD_CYC cycles)
  - ss_n stays low and mosi holds its value.
  - Then: ss_n all 1, gnt=0, done[winner]=1, rx_data=shift register, last_served=winner, FSM to IDLE.
- **Request rules**
  - req is not an abort: dropping req mid-transfer does not affect the transfer, and done still pulses.
  - In the cycle done[i]=1, req[i] is masked for arbitration. req[i] still high on the following cycle is a new request.
  - Requests from other requesters that are pending while busy wait and are arbitrated in IDLE.
- **Idle levels:** outside a transfer, sclk holds its last level (cpol of the last served requester) and mosi holds its last value.

## Timing
- The IDLE cycle with an eligible req is followed by gnt/ss_n low on the next rising edge.
- gnt rise to done pulse: exactly 17*CLK_DIV + HOLD_CYC cycles. With defaults that is 70.
- Minimum gap with ss_n all high between transfers: 1 cycle (the done/IDLE cycle).
- Outputs are registered; no combinational path from req or miso to any output.
- miso is sampled on the clk edge on which sclk toggles.

## Configuration
- `SPI_SCHED_LOOPBACK_EN` defined: the shift-register input is internal mosi and the miso port is ignored, so rx_data equals the captured tx byte. This supports self-test.
- Not defined: the shift-register input is the miso port, as described under Operation.

## Test plan
- **Reset:** hold rst_n=0 with random inputs -> all outputs at the reset values above. Asserting rst_n=0 mid-XFER (after edge 5) -> ss_n all 1 and sclk=0 in the same cycle, and no done. After release with req[2] still high, a full fresh transfer to requester 2.
- **Mode 0:** req[0], tx 0x73, cpol=0, cpha=0, slave model returns 0xA5 -> mosi 0,1,1,1,0,0,1,1 valid at each rising sclk; done[0] 70 cycles after gnt[0]; rx_data=0xA5.
- **Mode 3:** req[1], tx 0xC3, cpol=1, cpha=1 -> sclk high in SETUP, mosi changes on falling edges, 8 rising sample edges; rx matches the slave byte 0x5A.
- **Arbitration:** req=4'b1111 from reset -> grants in order 0,1,2,3. Then hold req[0] and req[2] high continuously -> alternation 0,2,0,2 with exactly one idle cycle between transfers.
- **Request drop:** req[3] drops during XFER -> transfer completes and done[3] pulses.
- **Loopback:** with `SPI_SCHED_LOOPBACK_EN` defined, tx 0x3C and miso tied to 1 -> rx_data=0x3C.
